// File: rtl/id_stage_pipe_if.sv
// ID/EX output channel of the decode stage.
//   out_valid    : payload below is valid (driven by the decode stage)
//   out_ready    : EX stage accepts the payload (driven by EX)
//   pc_o         : registered PC of the decoded instruction
//   aluop_o      : ALU operation code
//   alusel_o     : ALU result-group select
//   reg1_o/reg2_o: resolved source operands
//   wd_o         : destination register address
//   wreg_o       : destination write enable
//   inst_invalid_o: instruction word was not recognised
// The master modport is the decode stage; the slave modport is EX.
interface id_stage_pipe_if #(
  parameter int DW  = 32,
  parameter int AW  = 32,
  parameter int RAW = 5
);
  logic           out_valid;
  logic           out_ready;
  logic [AW-1:0]  pc_o;
  logic [7:0]     aluop_o;
  logic [2:0]     alusel_o;
  logic [DW-1:0]  reg1_o;
  logic [DW-1:0]  reg2_o;
  logic [RAW-1:0] wd_o;
  logic           wreg_o;
  logic           inst_invalid_o;

  modport master (
    output out_valid, pc_o, aluop_o, alusel_o, reg1_o, reg2_o,
           wd_o, wreg_o, inst_invalid_o,
    input  out_ready
  );

  modport slave (
    input  out_valid, pc_o, aluop_o, alusel_o, reg1_o, reg2_o,
           wd_o, wreg_o, inst_invalid_o,
    output out_ready
  );
endinterface

// File: rtl/id_stage_pipe.sv
// Registered instruction-decode stage for the OpenMIPS 5-stage pipeline.
// Decodes logic, shift, sync and pref instructions, drives the regfile read
// ports, resolves operands with EX/MEM forwarding, stalls on load-use
// hazards and holds the result in an ID/EX register behind valid/ready.
// Ports:
//   clk, rst                 : clock, synchronous active-high reset
//   in_valid/in_ready        : upstream handshake for pc_i/inst_i
//   pc_i, inst_i             : instruction PC and word from IF/ID
//   reg{1,2}_addr_o/_re_o    : regfile read address / enable (combinational)
//   reg{1,2}_data_i          : regfile read data (same cycle)
//   ex_* / mem_*             : writeback info of the EX and MEM stages
//   flush_i                  : drop the input and empty the output register
//   ex_bus                   : ID/EX output channel (id_stage_pipe_if.master)
module id_stage_pipe #(
  parameter int DW  = 32,
  parameter int AW  = 32,
  parameter int RAW = 5
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [AW-1:0]  pc_i,
  input  logic [31:0]    inst_i,
  output logic [RAW-1:0] reg1_addr_o,
  output logic [RAW-1:0] reg2_addr_o,
  output logic           reg1_re_o,
  output logic           reg2_re_o,
  input  logic [DW-1:0]  reg1_data_i,
  input  logic [DW-1:0]  reg2_data_i,
  input  logic           ex_wreg_i,
  input  logic [RAW-1:0] ex_wd_i,
  input  logic [DW-1:0]  ex_wdata_i,
  input  logic           ex_is_load_i,
  input  logic           mem_wreg_i,
  input  logic [RAW-1:0] mem_wd_i,
  input  logic [DW-1:0]  mem_wdata_i,
  input  logic           flush_i,
  id_stage_pipe_if.master ex_bus
);

  localparam logic [7:0] OP_NOP = 8'h00;
  localparam logic [7:0] OP_OR  = 8'h25;
  localparam logic [7:0] OP_AND = 8'h24;
  localparam logic [7:0] OP_XOR = 8'h26;
  localparam logic [7:0] OP_NOR = 8'h27;
  localparam logic [7:0] OP_SLL = 8'h7C;
  localparam logic [7:0] OP_SRL = 8'h02;
  localparam logic [7:0] OP_SRA = 8'h03;

  localparam logic [2:0] SEL_NOP   = 3'b000;
  localparam logic [2:0] SEL_LOGIC = 3'b001;
  localparam logic [2:0] SEL_SHIFT = 3'b010;

  // Instruction fields
  logic [5:0] op;
  logic [4:0] rs, rt, rd, sa;
  logic [5:0] funct;

  assign op    = inst_i[31:26];
  assign rs    = inst_i[25:21];
  assign rt    = inst_i[20:16];
  assign rd    = inst_i[15:11];
  assign sa    = inst_i[10:6];
  assign funct = inst_i[5:0];

  // Decoder outputs
  logic [7:0]     dec_aluop;
  logic [2:0]     dec_alusel;
  logic           dec_re1, dec_re2;
  logic [RAW-1:0] dec_wd;
  logic           dec_wreg;
  logic           dec_invalid;
  logic [DW-1:0]  dec_imm;

  always_comb begin
    dec_aluop   = OP_NOP;
    dec_alusel  = SEL_NOP;
    dec_re1     = 1'b0;
    dec_re2     = 1'b0;
    dec_wd      = RAW'(rd);
    dec_wreg    = 1'b0;
    dec_invalid = 1'b1;
    dec_imm     = '0;
    case (op)
      6'h00: begin
        case (funct)
          6'h25, 6'h24, 6'h26, 6'h27: begin
            if (sa == 5'd0) begin
              dec_alusel  = SEL_LOGIC;
              dec_re1     = 1'b1;
              dec_re2     = 1'b1;
              dec_wreg    = 1'b1;
              dec_invalid = 1'b0;
              case (funct)
                6'h25:   dec_aluop = OP_OR;
                6'h24:   dec_aluop = OP_AND;
                6'h26:   dec_aluop = OP_XOR;
                default: dec_aluop = OP_NOR;
              endcase
            end
          end
          6'h04, 6'h06, 6'h07: begin
            if (sa == 5'd0) begin
              dec_alusel  = SEL_SHIFT;
              dec_re1     = 1'b1;
              dec_re2     = 1'b1;
              dec_wreg    = 1'b1;
              dec_invalid = 1'b0;
              case (funct)
                6'h04:   dec_aluop = OP_SLL;
                6'h06:   dec_aluop = OP_SRL;
                default: dec_aluop = OP_SRA;
              endcase
            end
          end
          6'h0F: begin
            if (sa == 5'd0) begin
              dec_re2     = 1'b1;
              dec_invalid = 1'b0;
            end
          end
          6'h00, 6'h02, 6'h03: begin
            // Immediate shifts require rs (and the opcode) to be zero.
            if (inst_i[31:21] == 11'd0) begin
              dec_alusel  = SEL_SHIFT;
              dec_re2     = 1'b1;
              dec_wreg    = 1'b1;
              dec_invalid = 1'b0;
              dec_imm     = DW'(sa);
              case (funct)
                6'h00:   dec_aluop = OP_SLL;
                6'h02:   dec_aluop = OP_SRL;
                default: dec_aluop = OP_SRA;
              endcase
            end
          end
          default: ;
        endcase
      end
      6'h0D, 6'h0C, 6'h0E, 6'h0F: begin
        dec_alusel  = SEL_LOGIC;
        dec_re1     = 1'b1;
        dec_wd      = RAW'(rt);
        dec_wreg    = 1'b1;
        dec_invalid = 1'b0;
        dec_imm     = DW'(inst_i[15:0]);
        case (op)
          6'h0D:   dec_aluop = OP_OR;
          6'h0C:   dec_aluop = OP_AND;
          6'h0E:   dec_aluop = OP_XOR;
          default: begin
            // lui is an OR of $0 with the upper-half immediate
            dec_aluop = OP_OR;
            dec_imm   = DW'({inst_i[15:0], 16'h0000});
          end
        endcase
      end
      6'h33: dec_invalid = 1'b0;
      default: ;
    endcase
  end

  assign reg1_addr_o = RAW'(rs);
  assign reg2_addr_o = RAW'(rt);
  assign reg1_re_o   = dec_re1;
  assign reg2_re_o   = dec_re2;

  // Per-port operand resolution and load-use detection
  logic [RAW-1:0] rd_addr     [2];
  logic           rd_en       [2];
  logic [DW-1:0]  rf_data     [2];
  logic [DW-1:0]  operand     [2];
  logic           port_hazard [2];

  assign rd_addr[0] = reg1_addr_o;
  assign rd_addr[1] = reg2_addr_o;
  assign rd_en[0]   = dec_re1;
  assign rd_en[1]   = dec_re2;
  assign rf_data[0] = reg1_data_i;
  assign rf_data[1] = reg2_data_i;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_port
      // EX is the younger producer, so it takes priority over MEM.
      assign operand[gi] =
          !rd_en[gi]                                  ? dec_imm     :
          (rd_addr[gi] == '0)                         ? '0          :
          (ex_wreg_i  && (ex_wd_i  == rd_addr[gi]))   ? ex_wdata_i  :
          (mem_wreg_i && (mem_wd_i == rd_addr[gi]))   ? mem_wdata_i :
                                                        rf_data[gi];
      assign port_hazard[gi] = ex_is_load_i && ex_wreg_i && (ex_wd_i != '0) &&
                               rd_en[gi] && (ex_wd_i == rd_addr[gi]);
    end
  endgenerate

  logic hazard;
  logic load_en;

  assign hazard   = port_hazard[0] || port_hazard[1];
  assign load_en  = !ex_bus.out_valid || ex_bus.out_ready;
  assign in_ready = flush_i || (load_en && !hazard);

  // ID/EX register
  always_ff @(posedge clk) begin
    if (rst) begin
      ex_bus.out_valid      <= 1'b0;
      ex_bus.pc_o           <= '0;
      ex_bus.aluop_o        <= OP_NOP;
      ex_bus.alusel_o       <= SEL_NOP;
      ex_bus.reg1_o         <= '0;
      ex_bus.reg2_o         <= '0;
      ex_bus.wd_o           <= '0;
      ex_bus.wreg_o         <= 1'b0;
      ex_bus.inst_invalid_o <= 1'b0;
    end else if (flush_i) begin
      ex_bus.out_valid <= 1'b0;
    end else if (load_en) begin
      ex_bus.out_valid <= in_valid && !hazard;
      if (in_valid && !hazard) begin
        ex_bus.pc_o           <= pc_i;
        ex_bus.aluop_o        <= dec_aluop;
        ex_bus.alusel_o       <= dec_alusel;
        ex_bus.reg1_o         <= operand[0];
        ex_bus.reg2_o         <= operand[1];
        ex_bus.wd_o           <= dec_wd;
        ex_bus.wreg_o         <= dec_wreg;
        ex_bus.inst_invalid_o <= dec_invalid;
      end
    end
  end

endmodule

// File: tb/tb_id_stage_pipe.sv
// Directed-vector bench for id_stage_pipe (DW=32 instance plus a DW=64
// instance for the wide-immediate case).
module tb_id_stage_pipe;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // ---------------- DW=32 instance ----------------
  logic        in_valid, in_ready;
  logic [31:0] pc_i, inst_i;
  logic [4:0]  reg1_addr_o, reg2_addr_o;
  logic        reg1_re_o, reg2_re_o;
  logic [31:0] reg1_data_i, reg2_data_i;
  logic        ex_wreg_i, ex_is_load_i, mem_wreg_i, flush_i;
  logic [4:0]  ex_wd_i, mem_wd_i;
  logic [31:0] ex_wdata_i, mem_wdata_i;

  id_stage_pipe_if #(.DW(32), .AW(32), .RAW(5)) bus32 ();

  id_stage_pipe #(.DW(32), .AW(32), .RAW(5)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .pc_i(pc_i), .inst_i(inst_i),
    .reg1_addr_o(reg1_addr_o), .reg2_addr_o(reg2_addr_o),
    .reg1_re_o(reg1_re_o), .reg2_re_o(reg2_re_o),
    .reg1_data_i(reg1_data_i), .reg2_data_i(reg2_data_i),
    .ex_wreg_i(ex_wreg_i), .ex_wd_i(ex_wd_i), .ex_wdata_i(ex_wdata_i),
    .ex_is_load_i(ex_is_load_i),
    .mem_wreg_i(mem_wreg_i), .mem_wd_i(mem_wd_i), .mem_wdata_i(mem_wdata_i),
    .flush_i(flush_i),
    .ex_bus(bus32)
  );

  // ---------------- DW=64 instance ----------------
  logic        in_valid64, in_ready64;
  logic [31:0] pc64, inst64;
  logic [4:0]  r1a64, r2a64;
  logic        r1e64, r2e64;

  id_stage_pipe_if #(.DW(64), .AW(32), .RAW(5)) bus64 ();

  id_stage_pipe #(.DW(64), .AW(32), .RAW(5)) dut64 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid64), .in_ready(in_ready64),
    .pc_i(pc64), .inst_i(inst64),
    .reg1_addr_o(r1a64), .reg2_addr_o(r2a64),
    .reg1_re_o(r1e64), .reg2_re_o(r2e64),
    .reg1_data_i(64'h0), .reg2_data_i(64'h0),
    .ex_wreg_i(1'b0), .ex_wd_i(5'd0), .ex_wdata_i(64'h0), .ex_is_load_i(1'b0),
    .mem_wreg_i(1'b0), .mem_wd_i(5'd0), .mem_wdata_i(64'h0),
    .flush_i(1'b0),
    .ex_bus(bus64)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_out(input string tag, input logic [31:0] pc, input logic [7:0] aluop,
                           input logic [2:0] alusel, input logic [31:0] r1, input logic [31:0] r2,
                           input logic [4:0] wd, input logic wreg, input logic inv);
    check({tag, ".valid"}, 64'(bus32.out_valid), 64'd1);
    check({tag, ".pc"}, 64'(bus32.pc_o), 64'(pc));
    check({tag, ".aluop"}, 64'(bus32.aluop_o), 64'(aluop));
    check({tag, ".alusel"}, 64'(bus32.alusel_o), 64'(alusel));
    check({tag, ".reg1"}, 64'(bus32.reg1_o), 64'(r1));
    check({tag, ".reg2"}, 64'(bus32.reg2_o), 64'(r2));
    check({tag, ".wd"}, 64'(bus32.wd_o), 64'(wd));
    check({tag, ".wreg"}, 64'(bus32.wreg_o), 64'(wreg));
    check({tag, ".inv"}, 64'(bus32.inst_invalid_o), 64'(inv));
    $display("txn %s pc=%h aluop=%h reg1=%h reg2=%h", tag, bus32.pc_o, bus32.aluop_o,
             bus32.reg1_o, bus32.reg2_o);
  endtask

  initial begin
    rst = 1'b1;
    in_valid = 0; pc_i = 0; inst_i = 0;
    reg1_data_i = 0; reg2_data_i = 0;
    ex_wreg_i = 0; ex_wd_i = 0; ex_wdata_i = 0; ex_is_load_i = 0;
    mem_wreg_i = 0; mem_wd_i = 0; mem_wdata_i = 0; flush_i = 0;
    bus32.out_ready = 1'b1;
    in_valid64 = 0; pc64 = 0; inst64 = 0;
    bus64.out_ready = 1'b1;

    tick();
    tick();
    // Reset state
    check("rst.valid", 64'(bus32.out_valid), 64'd0);
    check("rst.pc", 64'(bus32.pc_o), 64'd0);
    check("rst.aluop", 64'(bus32.aluop_o), 64'd0);
    check("rst.alusel", 64'(bus32.alusel_o), 64'd0);
    check("rst.reg1", 64'(bus32.reg1_o), 64'd0);
    check("rst.reg2", 64'(bus32.reg2_o), 64'd0);
    check("rst.wd", 64'(bus32.wd_o), 64'd0);
    check("rst.wreg", 64'(bus32.wreg_o), 64'd0);
    check("rst.inv", 64'(bus32.inst_invalid_o), 64'd0);
    check("rst.valid64", 64'(bus64.out_valid), 64'd0);
    $display("txn reset done");
    rst = 1'b0;

    // ori $1,$0,0x1100 ; DW=64 lui $5,0x8000 in parallel
    in_valid = 1; pc_i = 32'h100; inst_i = 32'h34011100;
    in_valid64 = 1; pc64 = 32'h200; inst64 = 32'h3C058000;
    #1;
    check("ori.in_ready", 64'(in_ready), 64'd1);
    check("ori.re1", 64'(reg1_re_o), 64'd1);
    check("ori.re2", 64'(reg2_re_o), 64'd0);
    tick();
    check_out("ori", 32'h100, 8'h25, 3'd1, 32'h0, 32'h00001100, 5'd1, 1'b1, 1'b0);
    check("lui64.valid", 64'(bus64.out_valid), 64'd1);
    check("lui64.reg2", bus64.reg2_o, 64'h0000_0000_8000_0000);
    check("lui64.aluop", 64'(bus64.aluop_o), 64'h25);
    check("lui64.wd", 64'(bus64.wd_o), 64'd5);
    $display("txn lui64 reg2=%h", bus64.reg2_o);
    in_valid64 = 0;

    // or $3,$1,$2 with EX fwd on $1, MEM fwd on $2
    pc_i = 32'h104; inst_i = 32'h00221825;
    ex_wreg_i = 1; ex_wd_i = 5'd1; ex_wdata_i = 32'hDEADBEEF;
    mem_wreg_i = 1; mem_wd_i = 5'd2; mem_wdata_i = 32'h0000FFFF;
    reg1_data_i = 32'h12345678; reg2_data_i = 32'h12345678;
    tick();
    check_out("or.fwd", 32'h104, 8'h25, 3'd1, 32'hDEADBEEF, 32'h0000FFFF, 5'd3, 1'b1, 1'b0);
    check("fwd64.valid_cleared", 64'(bus64.out_valid), 64'd0);

    // EX and MEM both target $1: EX wins; $2 now from regfile
    pc_i = 32'h108; mem_wd_i = 5'd1;
    tick();
    check_out("or.exwins", 32'h108, 8'h25, 3'd1, 32'hDEADBEEF, 32'h12345678, 5'd3, 1'b1, 1'b0);

    // Load-use hazard on $1
    pc_i = 32'h10C; ex_is_load_i = 1; mem_wreg_i = 0;
    #1;
    check("hz.in_ready", 64'(in_ready), 64'd0);
    tick();
    check("hz.bubble", 64'(bus32.out_valid), 64'd0);
    $display("txn hazard bubble");
    ex_is_load_i = 0; ex_wreg_i = 0;
    mem_wreg_i = 1; mem_wd_i = 5'd1; mem_wdata_i = 32'hAAAA5555;
    reg2_data_i = 32'h11111111;
    #1;
    check("hz.release_ready", 64'(in_ready), 64'd1);
    tick();
    check_out("hz.issue", 32'h10C, 8'h25, 3'd1, 32'hAAAA5555, 32'h11111111, 5'd3, 1'b1, 1'b0);
    mem_wreg_i = 0;

    // Backpressure: sll $2,$3,4 waits while EX stalls
    bus32.out_ready = 0;
    pc_i = 32'h110; inst_i = 32'h00031100; reg2_data_i = 32'h0000F0F0;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("bp.in_ready", 64'(in_ready), 64'd0);
      tick();
      check("bp.hold_valid", 64'(bus32.out_valid), 64'd1);
      check("bp.hold_pc", 64'(bus32.pc_o), 64'h10C);
      check("bp.hold_reg1", 64'(bus32.reg1_o), 64'hAAAA5555);
      $display("txn backpressure hold %0d", i);
    end
    check("sll.re1", 64'(reg1_re_o), 64'd0);
    check("sll.re2", 64'(reg2_re_o), 64'd1);
    bus32.out_ready = 1;
    #1;
    check("bp.release_ready", 64'(in_ready), 64'd1);
    tick();
    check_out("sll", 32'h110, 8'h7C, 3'd2, 32'h4, 32'h0000F0F0, 5'd2, 1'b1, 1'b0);

    // Full rate: invalid word, andi, pref on consecutive cycles
    pc_i = 32'h114; inst_i = 32'hFC000000;
    tick();
    check_out("invalid", 32'h114, 8'h00, 3'd0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b1);
    pc_i = 32'h118; inst_i = 32'h304400FF; reg1_data_i = 32'h0F0F0F0F;
    tick();
    check_out("andi", 32'h118, 8'h24, 3'd1, 32'h0F0F0F0F, 32'h000000FF, 5'd4, 1'b1, 1'b0);
    pc_i = 32'h11C; inst_i = 32'hCC000000;
    tick();
    check_out("pref", 32'h11C, 8'h00, 3'd0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0);

    // Flush during a stall (backpressure + hazard): input consumed, output cleared
    bus32.out_ready = 0;
    pc_i = 32'h120; inst_i = 32'h00221825;
    ex_wreg_i = 1; ex_wd_i = 5'd1; ex_is_load_i = 1;
    #1;
    check("fl.stall_ready", 64'(in_ready), 64'd0);
    flush_i = 1;
    #1;
    check("fl.in_ready", 64'(in_ready), 64'd1);
    tick();
    check("fl.valid", 64'(bus32.out_valid), 64'd0);
    flush_i = 0; in_valid = 0; ex_wreg_i = 0; ex_is_load_i = 0;
    bus32.out_ready = 1;
    tick();
    check("fl.dropped", 64'(bus32.out_valid), 64'd0);
    check("fl.pc_kept", 64'(bus32.pc_o), 64'h11C);
    $display("txn flush dropped");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got=running expected=finished");
    $fatal(1);
  end

endmodule
